// File: rtl/op_sequencer_pkg.sv
// Shared types and constants for the instruction-stream sequencer.
package op_sequencer_pkg;

  localparam int OP_CODE_W           = 3;
  localparam int COUNT_W             = 16;
  localparam int TMO_W               = 16;
  localparam int STATUS_W            = 32;
  localparam int DEFAULT_PROG_BASE   = 1;
  localparam int DEFAULT_STATUS_ADDR = 0;
  localparam int STATUS_COUNT_LSB    = 16;
  localparam int STATUS_ERR_LSB      = 0;

  // Engine op codes; NOP and HALT are consumed by the sequencer itself.
  typedef enum logic [OP_CODE_W-1:0] {
    NOP          = 3'd0,
    MAT_ADD      = 3'd1,
    MAT_SUB      = 3'd2,
    MAT_MUL      = 3'd3,
    MAT_SCAL_MUL = 3'd4,
    MAT_SCAL_INV = 3'd5,
    HALT         = 3'd7
  } op_code_t;

  // Descriptor layout: op code in the low bits, engine arguments above.
  typedef struct packed {
    logic [STATUS_W-OP_CODE_W-1:0] args;
    op_code_t                      op_code;
  } meta_data_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } seq_err_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_DISPATCH, S_EXEC, S_STATUS
  } state_t;

  // Status word: completed-op count in the upper half, error code at the bottom.
  function automatic logic [STATUS_W-1:0] status_word(input logic [COUNT_W-1:0] count,
                                                      input seq_err_t err);
    logic [STATUS_W-1:0] w;
    w = '0;
    w[STATUS_COUNT_LSB +: COUNT_W] = count;
    w[STATUS_ERR_LSB +: 2]         = err;
    return w;
  endfunction

endpackage

// File: rtl/op_sequencer_counter.sv
// Up-counter with synchronous clear and enable; used for pc, op count and timeout.
module op_sequencer_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] value
);

  // Count register; clear wins over enable.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// Fetches meta_data_t descriptors from instruction memory, hands them one at a
// time to the compute engine and writes a completion status word back.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          DATA_WIDTH  = 32,
  parameter int          PROG_BASE   = DEFAULT_PROG_BASE,
  parameter int          STATUS_ADDR = DEFAULT_STATUS_ADDR,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] prog_len,
  input  logic                  abort,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  op_valid,
  output logic [DATA_WIDTH-1:0] op_data,
  input  logic                  op_ready,
  input  logic                  op_done,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] PROG_BASE_A   = ADDR_WIDTH'(PROG_BASE);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR_A = ADDR_WIDTH'(STATUS_ADDR);
  localparam logic [TMO_W-1:0]      TMO_LIMIT     = TMO_W'(TIMEOUT);

  state_t                  state_q, state_d;
  seq_err_t                err_q, err_d;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [DATA_WIDTH-1:0]   op_q;
  logic                    abort_q;
  logic                    done_q;
  logic                    start_ok;
  logic                    pc_inc;
  logic                    count_inc;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [COUNT_W-1:0]      count_q;
  logic [TMO_W-1:0]        tmo_q;
  logic                    abort_pending;
  logic                    last_op;
  logic                    tmo_hit;
  op_code_t                rd_op;

  op_sequencer_counter #(.WIDTH(ADDR_WIDTH)) u_pc (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok),
    .enable (pc_inc),
    .value  (pc_q)
  );

  op_sequencer_counter #(.WIDTH(COUNT_W)) u_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok),
    .enable (count_inc),
    .value  (count_q)
  );

  // Counts EXEC cycles; held at zero whenever the engine is not executing.
  op_sequencer_counter #(.WIDTH(TMO_W)) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != S_EXEC),
    .enable (state_q == S_EXEC),
    .value  (tmo_q)
  );

  assign abort_pending = abort_q | abort;
  assign last_op       = (pc_q + ADDR_WIDTH'(1)) == len_q;
  assign tmo_hit       = (TIMEOUT != 0) && (tmo_q == TMO_LIMIT);
  assign rd_op         = op_code_t'(mem_readdata[OP_CODE_W-1:0]);

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err_code = err_q;
  assign pc       = pc_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: program length, current descriptor, error, abort flag, done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q   <= '0;
      op_q    <= '0;
      err_q   <= ERR_OK;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      err_q  <= err_d;
      done_q <= (state_q == S_STATUS);
      if (start_ok) begin
        len_q <= prog_len;
      end
      if (state_q == S_WAIT_RD) begin
        op_q <= mem_readdata;
      end
      if (start_ok) begin
        abort_q <= 1'b0;
      end else if (abort && (state_q != S_IDLE)) begin
        abort_q <= 1'b1;
      end
    end
  end

  // Next-state, counter strobes and memory/engine outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    err_d         = err_q;
    start_ok      = 1'b0;
    pc_inc        = 1'b0;
    count_inc     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    op_valid      = 1'b0;
    op_data       = '0;

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          start_ok = 1'b1;
          err_d    = ERR_OK;
          state_d  = (prog_len == '0) ? S_STATUS : S_FETCH;
        end
      end

      S_FETCH: begin
        mem_read    = 1'b1;
        mem_address = PROG_BASE_A + pc_q;
        state_d     = S_WAIT_RD;
      end

      S_WAIT_RD: begin
        case (rd_op)
          NOP: begin
            pc_inc = 1'b1;
            if (last_op) begin
              state_d = S_STATUS;
            end else if (abort_pending) begin
              err_d   = ERR_ABORT;
              state_d = S_STATUS;
            end else begin
              state_d = S_FETCH;
            end
          end
          HALT: begin
            state_d = S_STATUS;
          end
          MAT_ADD, MAT_SUB, MAT_MUL, MAT_SCAL_MUL, MAT_SCAL_INV: begin
            state_d = S_DISPATCH;
          end
          default: begin
            err_d   = ERR_ILLEGAL;
            state_d = S_STATUS;
          end
        endcase
      end

      S_DISPATCH: begin
        if (abort_pending) begin
          err_d   = ERR_ABORT;
          state_d = S_STATUS;
        end else begin
          op_valid = 1'b1;
          op_data  = op_q;
          if (op_ready) begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        // Completion beats timeout; a same-cycle abort still counts the op.
        if (op_done) begin
          pc_inc    = 1'b1;
          count_inc = 1'b1;
          if (abort_pending) begin
            err_d   = ERR_ABORT;
            state_d = S_STATUS;
          end else if (last_op) begin
            state_d = S_STATUS;
          end else begin
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_STATUS;
        end
      end

      S_STATUS: begin
        mem_write     = 1'b1;
        mem_address   = STATUS_ADDR_A;
        mem_writedata = DATA_WIDTH'(status_word(count_q, err_q));
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench: table of programs with expected results, a scoreboard of
// expected descriptors, an instruction-memory model and a scripted engine.
module tb_op_sequencer;

  localparam int TB_TIMEOUT = 50;
  localparam int TB_BASE    = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  prog_len = '0;
  logic        abort = 1'b0;
  logic        mem_read, mem_write;
  logic [9:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        op_valid;
  logic [31:0] op_data;
  logic        op_ready = 1'b0;
  logic        op_done = 1'b0;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [9:0]  pc;

  op_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .prog_len      (prog_len),
    .abort         (abort),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .op_valid      (op_valid),
    .op_data       (op_data),
    .op_ready      (op_ready),
    .op_done       (op_done),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .pc            (pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    int               len;
    logic [3:0][31:0] prog;
    int               ready_dly;   // op_valid cycles before op_ready rises
    int               done_dly;    // cycles from transfer to op_done (0 = never)
    int               abort_at;    // cycles after first transfer to pulse abort (-1 = never)
    bit               poke_start;  // extra start pulse while busy
    int               exp_xfers;
    int               exp_count;
    int               exp_err;
    int               exp_reads;
    int               exp_pc;
    int               exp_lat;     // transfer-to-status-write cycles (-1 = unchecked)
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] imem [0:1023];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Engine/memory observation state shared with the monitor.
  int          cycle = 0;
  int          ready_dly = 0;
  int          done_dly = 0;
  int          abort_at = -1;
  int          since_xfer = -1;
  int          done_cnt = 0;
  int          valid_cycles = 0;
  int          n_reads = 0;
  int          n_writes = 0;
  int          n_xfers = 0;
  int          xfer_cycle = 0;
  int          write_cycle = 0;
  bit          done_seen = 1'b0;
  bit          prev_write = 1'b0;
  logic [31:0] held_data = '0;
  logic [31:0] last_status = '0;
  logic [9:0]  last_addr = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input int len, input logic [31:0] p0, p1, p2, p3,
                         input int rdy, dn, ab, input bit poke,
                         input int xf, cnt, er, rd, pcv, lat);
    vec_t v;
    v.len = len;
    v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2; v.prog[3] = p3;
    v.ready_dly = rdy; v.done_dly = dn; v.abort_at = ab; v.poke_start = poke;
    v.exp_xfers = xf; v.exp_count = cnt; v.exp_err = er;
    v.exp_reads = rd; v.exp_pc = pcv; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, {25'd0, busy, done, mem_read, mem_write, op_valid, err_code}, 32'd0);
    check({tag, "_addr"}, {22'd0, mem_address}, 32'd0);
    check({tag, "_wdata"}, mem_writedata, 32'd0);
    check({tag, "_opdata"}, op_data, 32'd0);
    check({tag, "_pc"}, {22'd0, pc}, 32'd0);
  endtask

  // Memory model, engine model and scoreboard, all sampled on the falling edge.
  always @(negedge clock) begin
    cycle++;
    op_done = 1'b0;
    abort   = 1'b0;
    if (reset) begin
      valid_cycles = 0;
      done_cnt     = 0;
      op_ready     = 1'b0;
      prev_write   = 1'b0;
    end else begin
      if (mem_read) begin
        check("rd_wr_exclusive", {31'd0, mem_write}, 32'd0);
        check("rd_addr", {22'd0, mem_address}, 32'(TB_BASE + n_reads));
        mem_readdata = imem[mem_address];
        n_reads++;
      end
      if (mem_write) begin
        n_writes++;
        last_status = mem_writedata;
        last_addr   = mem_address;
        write_cycle = cycle;
      end
      if (done) begin
        check("done_follows_write", {31'd0, prev_write}, 32'd1);
        done_seen = 1'b1;
      end
      prev_write = mem_write;

      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) op_done = 1'b1;
      end
      if (since_xfer >= 0) begin
        since_xfer++;
        if (since_xfer == abort_at) abort = 1'b1;
      end

      if (op_valid) begin
        valid_cycles++;
        if (valid_cycles > 1) check("op_data_stable", op_data, held_data);
        held_data = op_data;
      end else begin
        valid_cycles = 0;
      end
      op_ready = op_valid && (valid_cycles > ready_dly);

      if (op_valid && op_ready) begin
        n_xfers++;
        xfer_cycle = cycle;
        check("xfer_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("descriptor", op_data, exp_q.pop_front());
        if (done_dly > 0) done_cnt = done_dly;
        if (n_xfers == 1) since_xfer = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  pushed;
    bit  got;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clock); #1;
    for (int i = 0; i < 4; i++) imem[TB_BASE + i] = v.prog[i];
    ready_dly = v.ready_dly; done_dly = v.done_dly; abort_at = v.abort_at;
    n_reads = 0; n_writes = 0; n_xfers = 0; done_seen = 1'b0;
    since_xfer = -1; done_cnt = 0; xfer_cycle = 0; write_cycle = 0;
    exp_q.delete();
    pushed = 0;
    for (int i = 0; i < v.len && i < 4; i++) begin
      if (v.prog[i][2:0] >= 3'd1 && v.prog[i][2:0] <= 3'd5 && pushed < v.exp_xfers) begin
        exp_q.push_back(v.prog[i]);
        pushed++;
      end
    end
    start = 1'b1;
    prog_len = 10'(v.len);
    @(negedge clock); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (v.poke_start && i == 5) begin
        start = 1'b1;
        prog_len = 10'd4;
      end else begin
        start = 1'b0;
      end
      if (done_seen) begin
        got = 1'b1;
        break;
      end
      @(negedge clock); #1;
    end
    start = 1'b0;
    check({t, "_done_seen"}, {31'd0, got}, 32'd1);
    check({t, "_xfers"}, n_xfers, v.exp_xfers);
    check({t, "_sb_empty"}, exp_q.size(), 0);
    check({t, "_reads"}, n_reads, v.exp_reads);
    check({t, "_writes"}, n_writes, 1);
    check({t, "_status"}, last_status, {v.exp_count[15:0], 14'd0, v.exp_err[1:0]});
    check({t, "_status_addr"}, {22'd0, last_addr}, 32'd0);
    check({t, "_err_code"}, {30'd0, err_code}, v.exp_err);
    check({t, "_pc"}, {22'd0, pc}, v.exp_pc);
    check({t, "_busy"}, {31'd0, busy}, 32'd0);
    if (v.exp_lat >= 0) check({t, "_latency"}, write_cycle - xfer_cycle, v.exp_lat);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = '0;

    //       len  prog words                                          rdy  dn  ab  poke xf cnt er rd pc lat
    add_vec(3, 32'h0000_1001, 32'h0000_2004, 32'h0000_3003, 32'h0,      0, 10, -1, 0,  3, 3, 0, 3, 3, -1);
    add_vec(4, 32'h0000_0000, 32'h0000_4001, 32'h0000_0007, 32'h0000_5001, 0, 4, -1, 0, 1, 1, 0, 3, 2, -1);
    add_vec(3, 32'h0000_6001, 32'h0000_0006, 32'h0000_7001, 32'h0,      0, 3, -1, 0,  1, 1, 1, 2, 1, -1);
    add_vec(1, 32'hABCD_E012, 32'h0, 32'h0, 32'h0,                      20, 3, -1, 1,  1, 1, 0, 1, 1, -1);
    add_vec(0, 32'h0000_1001, 32'h0, 32'h0, 32'h0,                      0, 3, -1, 0,  0, 0, 0, 0, 0, -1);
    add_vec(2, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0, 32'h0,              0, 3, -1, 0,  0, 0, 0, 2, 2, -1);
    add_vec(2, 32'h0000_8003, 32'h0000_9001, 32'h0, 32'h0,              0, 0, -1, 0,  1, 0, 2, 1, 0, TB_TIMEOUT + 2);
    add_vec(3, 32'h0000_A001, 32'h0000_B001, 32'h0000_C001, 32'h0,      0, 8,  3, 0,  1, 1, 3, 1, 1, -1);
    add_vec(3, 32'h0000_D005, 32'h0000_E001, 32'h0000_F001, 32'h0,      0, 10, 10, 0, 1, 1, 3, 1, 1, -1);

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], k);

    // A start in the same cycle as the done pulse is dropped.
    run_vec(vecs[4], 99);
    start = 1'b1;
    prog_len = 10'd1;
    @(negedge clock); #1;
    start = 1'b0;
    check("start_on_done_ignored", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    #1;
    check("start_on_done_no_read", n_reads, 0);

    // Reset while a descriptor is being offered.
    @(negedge clock); #1;
    imem[TB_BASE] = 32'h0000_1001;
    ready_dly = 1000; done_dly = 0; abort_at = -1;
    n_writes = 0; exp_q.delete();
    start = 1'b1;
    prog_len = 10'd1;
    @(negedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (op_valid) break;
      @(negedge clock); #1;
    end
    check("reached_dispatch", {31'd0, op_valid}, 32'd1);
    reset = 1'b1;
    @(negedge clock); #1;
    check_outputs_zero("mid_reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("mid_reset_no_write", n_writes, 0);
    check("mid_reset_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
